// File: rtl/pillar_animator.sv
// Pillar-rise animation: streams top-row draw / bottom-row erase pixel writes, one step per frame.
// Define PILLAR_FAST_SIM_EN to shorten the inter-step wait to 4 cycles for simulation.
module pillar_animator #(
    parameter logic [8:0] X0            = 9'd150,
    parameter int         WIDTH         = 16,
    parameter int         HEIGHT        = 48,
    parameter logic [7:0] Y_BASE        = 8'd200,
    parameter int         RISE          = 40,
    parameter int         FRAME_DIV     = 833333,
    parameter logic [2:0] PILLAR_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startAnimation,
    output logic       doneAnimation,
    output logic       plot,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour
);

    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int STEP_W = $clog2(RISE + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RISE - 1);

`ifdef PILLAR_FAST_SIM_EN
    localparam int DIV_W = 2;
    localparam logic [DIV_W-1:0] DIV_LAST = 2'd3;
`else
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
`endif

    // Row of the top edge at step 0 and of the bottom edge at step 0.
    localparam logic [7:0] TOP_ROW0 = Y_BASE - 8'(HEIGHT) - 8'd1;
    localparam logic [7:0] BOT_ROW0 = Y_BASE - 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        DRAW_TOP,
        ERASE_BOT,
        WAIT_TICK,
        DONE
    } animState_t;

    animState_t        state;
    logic [STEP_W-1:0] step;
    logic [COL_W-1:0]  col;
    logic [DIV_W-1:0]  div;
    logic              abortReq;

    assign abortReq = !startAnimation &&
                      (state == DRAW_TOP || state == ERASE_BOT || state == WAIT_TICK);

    // Outputs are loaded together with the state they describe, so plot/x/y/colour
    // always reflect the registered state and counters and hold while plot is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            step          <= '0;
            col           <= '0;
            div           <= '0;
            doneAnimation <= 1'b0;
            plot          <= 1'b0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
        end else if (abortReq) begin
            state <= IDLE;
            step  <= '0;
            col   <= '0;
            div   <= '0;
            plot  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    step          <= '0;
                    col           <= '0;
                    div           <= '0;
                    doneAnimation <= 1'b0;
                    plot          <= 1'b0;
                    if (startAnimation) begin
                        state  <= DRAW_TOP;
                        plot   <= 1'b1;
                        x      <= X0;
                        y      <= TOP_ROW0;
                        colour <= PILLAR_COLOUR;
                    end
                end
                DRAW_TOP: begin
                    if (col == COL_LAST) begin
                        col    <= '0;
                        state  <= ERASE_BOT;
                        x      <= X0;
                        y      <= BOT_ROW0 - 8'(step);
                        colour <= BG_COLOUR;
                    end else begin
                        col <= col + 1'b1;
                        x   <= X0 + 9'(col) + 9'd1;
                    end
                end
                ERASE_BOT: begin
                    if (col == COL_LAST) begin
                        col  <= '0;
                        step <= step + 1'b1;
                        plot <= 1'b0;
                        if (step == STEP_LAST) begin
                            state         <= DONE;
                            doneAnimation <= 1'b1;
                        end else begin
                            div   <= '0;
                            state <= WAIT_TICK;
                        end
                    end else begin
                        col <= col + 1'b1;
                        x   <= X0 + 9'(col) + 9'd1;
                    end
                end
                WAIT_TICK: begin
                    if (div == DIV_LAST) begin
                        div    <= '0;
                        state  <= DRAW_TOP;
                        plot   <= 1'b1;
                        x      <= X0;
                        y      <= TOP_ROW0 - 8'(step);
                        colour <= PILLAR_COLOUR;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DONE: begin
                    plot <= 1'b0;
                    if (!startAnimation) begin
                        state         <= IDLE;
                        doneAnimation <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    plot          <= 1'b0;
                    doneAnimation <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pillar_animator.sv
// Self-checking bench for pillar_animator: randomized run lengths, aborts and resets vs. an arithmetic model.
module tb_pillar_animator;

    localparam int W        = 16;
    localparam int H        = 48;
    localparam int X0       = 150;
    localparam int YB       = 200;
    localparam int RISE     = 40;
    localparam int WAIT     = 4;
    localparam int STEP_LEN = 2 * W + WAIT;
    localparam int DONE_AT  = RISE * 2 * W + (RISE - 1) * WAIT;

    logic       clock = 1'b0;
    logic       reset;
    logic       startAnimation;
    logic       doneAnimation;
    logic       plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;

    int testsRun    = 0;
    int testsFailed = 0;
    int holdX, holdY, holdC;
    int plotCount, doneRise;

    always #5 clock = ~clock;

    // The wait is forced to 4 cycles whether or not the fast-sim build is selected.
    pillar_animator #(.FRAME_DIV(WAIT)) dut (
        .clock         (clock),
        .reset         (reset),
        .startAnimation(startAnimation),
        .doneAnimation (doneAnimation),
        .plot          (plot),
        .x             (x),
        .y             (y),
        .colour        (colour)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
        testsRun++;
        if (got !== 32'(exp)) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected behaviour k cycles after the edge that sampled the start request.
    function automatic void model(input int k, output bit p, output bit d,
                                  output int ex, output int ey, output int ec);
        int s, r;
        s  = k / STEP_LEN;
        r  = k % STEP_LEN;
        p  = 0;
        d  = 0;
        ex = 0;
        ey = 0;
        ec = 0;
        if (s > RISE - 1 || (s == RISE - 1 && r >= 2 * W)) begin
            d = 1;
        end else if (r < W) begin
            p = 1; ex = X0 + r;     ey = YB - H - 1 - s; ec = 6;
        end else if (r < 2 * W) begin
            p = 1; ex = X0 + r - W; ey = YB - 1 - s;     ec = 0;
        end
    endfunction

    task automatic checkCycle(input int k);
        bit p, d;
        int ex, ey, ec;
        model(k, p, d, ex, ey, ec);
        if (p) begin
            holdX = ex; holdY = ey; holdC = ec;
        end
        checkVal($sformatf("plot@%0d", k), 32'(plot), int'(p));
        checkVal($sformatf("done@%0d", k), 32'(doneAnimation), int'(d));
        checkVal($sformatf("x@%0d", k), 32'(x), holdX);
        checkVal($sformatf("y@%0d", k), 32'(y), holdY);
        checkVal($sformatf("colour@%0d", k), 32'(colour), holdC);
        if (plot === 1'b1) plotCount++;
        if (doneAnimation === 1'b1 && doneRise < 0) doneRise = k;
    endtask

    task automatic runAnim(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            checkCycle(k);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "_plot"}, 32'(plot), 0);
        checkVal({tag, "_done"}, 32'(doneAnimation), 0);
        checkVal({tag, "_x"}, 32'(x), holdX);
        checkVal({tag, "_y"}, 32'(y), holdY);
        checkVal({tag, "_colour"}, 32'(colour), holdC);
    endtask

    task automatic checkResetVals(input string tag);
        holdX = 0; holdY = 0; holdC = 0;
        checkIdle(tag);
    endtask

    initial begin
        int a;
        reset          = 1'b1;
        startAnimation = 1'b0;
        holdX = 0; holdY = 0; holdC = 0;
        repeat (3) @(negedge clock);
        checkResetVals("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkIdle("idle");

        // Full rise, then start held 100 cycles in DONE, then released.
        startAnimation = 1'b1;
        plotCount = 0;
        doneRise  = -1;
        runAnim(DONE_AT + 100);
        checkVal("plot_count", 32'(plotCount), RISE * 2 * W);
        checkVal("done_rise", 32'(doneRise), DONE_AT);
        startAnimation = 1'b0;
        @(negedge clock);
        checkIdle("done_drop");
        $display("[TB] full rise: %0d plots, done after %0d edges", plotCount, doneRise);

        // Abort during step 5 erase, then restart from step 0.
        a = 5 * STEP_LEN + W + int'($urandom_range(0, W - 1));
        startAnimation = 1'b1;
        runAnim(a);
        startAnimation = 1'b0;
        @(negedge clock);
        checkIdle("abort5");
        startAnimation = 1'b1;
        runAnim(2 * STEP_LEN);
        startAnimation = 1'b0;
        @(negedge clock);
        checkIdle("abort_restart");
        $display("[TB] abort at cycle %0d then restart", a);

        // Random aborts anywhere, including inside DONE.
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(1, DONE_AT + 60));
            startAnimation = 1'b1;
            runAnim(a);
            startAnimation = 1'b0;
            @(negedge clock);
            checkIdle($sformatf("abort_rand%0d", i));
            repeat (int'($urandom_range(1, 3))) @(negedge clock);
            checkIdle($sformatf("abort_quiet%0d", i));
            $display("[TB] random abort %0d at cycle %0d", i, a);
        end

        // Asynchronous reset mid-cycle with start held high, at cycle 700 and at a random cycle.
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 700 : int'($urandom_range(1, DONE_AT + 20));
            startAnimation = 1'b1;
            runAnim(a);
            #2 reset = 1'b1;
            #1 checkResetVals($sformatf("async_reset%0d", i));
            @(negedge clock);
            reset = 1'b0;
            runAnim(STEP_LEN + 10);
            startAnimation = 1'b0;
            @(negedge clock);
            checkIdle($sformatf("reset_restart%0d", i));
            $display("[TB] reset at cycle %0d then restart", a);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pillar_animator.md
# pillar_animator

Drives the pillar-rise animation requested by the game-state controller. While `startAnimation` is high, it scrolls a rectangular pillar upward one pixel per frame by streaming pixel writes into the frame-buffer/VGA plot path. Once the full rise is drawn, it raises `doneAnimation` so the game-state controller can advance to its pillar redraw state. It sits between the game-state controller (upstream) and the plot multiplexer in front of the VGA adapter (downstream).

## Interface
- `X0`, 9'd150, left column of pillar
- `WIDTH`, 16, pillar width in pixels (1..64)
- `HEIGHT`, 48, pillar height in pixels
- `Y_BASE`, 8'd200, row just below the pillar's initial bottom edge
- `RISE`, 40, total pixels risen (number of steps, ≥1)
- `FRAME_DIV`, 833333, clock cycles waited between steps (60 Hz at 50 MHz)
- `PILLAR_COLOUR`, 3'b110, colour of the drawn top row
- `BG_COLOUR`, 3'b000, colour of the erased bottom row
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  reset; one clock, asynchronous and active-high
- `startAnimation`  in  1  level request from game-state controller
- `doneAnimation`  out  1  level; high in DONE state
- `plot`  out  1  pixel write strobe
- `x`  out  9  pixel column
- `y`  out  8  pixel row
- `colour`  out  3  pixel colour

## Operation
- States: IDLE, DRAW_TOP, ERASE_BOT, WAIT_TICK, DONE.
- Registers:
  - `step`: completed steps, 0..RISE.
  - `col`: 0..WIDTH-1.
  - `div`: frame counter, wide enough for FRAME_DIV-1.
- IDLE: `step`, `col`, and `div` are cleared. On `startAnimation`=1, go to DRAW_TOP.
- DRAW_TOP:
  - Each cycle, `plot`=1, `x`=X0+`col`, `y`=Y_BASE-HEIGHT-1-`step`, `colour`=PILLAR_COLOUR.
  - At `col`=WIDTH-1, clear `col` and go to ERASE_BOT; otherwise increment `col`.
- ERASE_BOT:
  - Each cycle, `plot`=1, `x`=X0+`col`, `y`=Y_BASE-1-`step`, `colour`=BG_COLOUR.
  - At `col`=WIDTH-1, clear `col` and increment `step`. If the new `step`=RISE, go to DONE; else clear `div` and go to WAIT_TICK.
- WAIT_TICK: `plot`=0. `div` increments each cycle; at `div`=FRAME_DIV-1, go to DRAW_TOP.
- DONE: `doneAnimation`=1, `plot`=0. Stay in DONE while `startAnimation`=1; go to IDLE when it drops.
- Abort: `startAnimation`=0 in DRAW_TOP, ERASE_BOT or WAIT_TICK returns to IDLE on the next edge. Counters clear and no further plots occur. The partially risen pillar is left as drawn; the game-state controller's full redraw repairs it.
- Re-trigger: a new animation needs `startAnimation` low for at least one cycle (via IDLE). Holding it high after DONE never restarts the animation.
- Arithmetic: `x` and `y` are computed in 9 and 8 bits and wrap modulo width. Parameters are chosen so Y_BASE-HEIGHT-RISE ≥ 0 and X0+WIDTH ≤ 320; no saturation logic is required.
- When `plot`=0, `x`, `y` and `colour` are don't-care but must not toggle (hold their last values).

## Timing
- All outputs are decoded from registered state and counters only. There is no combinational path from `startAnimation` to any output.
- Reset values: state IDLE, `doneAnimation`=0, `plot`=0, `x`=0, `y`=0, `colour`=0, all counters 0.
- First plot appears in the cycle after the edge that samples `startAnimation`=1 in IDLE.
- Each step is 2·WIDTH plot cycles, followed by FRAME_DIV wait cycles (no wait after the final step).
- `doneAnimation` rises RISE·2·WIDTH + (RISE-1)·FRAME_DIV edges after the start-sampling edge.
- `doneAnimation` falls one edge after `startAnimation` is sampled low.
- Reset asserted mid-operation forces IDLE immediately, with outputs at their reset values; a held `startAnimation` restarts from step 0 after release.

## Configuration
- `PILLAR_FAST_SIM_EN`:
  - Defined: WAIT_TICK lasts exactly 4 cycles regardless of FRAME_DIV, and `div` is 2 bits wide. This is for simulation.
  - Undefined: WAIT_TICK lasts FRAME_DIV cycles as specified.
  - Nothing else changes.

## Test plan
All scenarios use defaults with `PILLAR_FAST_SIM_EN` defined.
- Start pulse held high: exactly 1280 cycles have `plot`=1. `doneAnimation` rises 1436 edges after the sampling edge.
- Step 0 check:
  - Plots at `y`=151 with `x`=150..165 and `colour`=3'b110.
  - Then `y`=199 with `x`=150..165 and `colour`=3'b000.
  - Then 4 cycles with `plot`=0.
- Last step (step 39): top row `y`=112, erase row `y`=160. DONE follows the erase with no wait. Drop start: `doneAnimation` is 0 one edge later, state IDLE.
- Abort: drop `startAnimation` during step 5 ERASE_BOT. `plot`=0 from the next cycle. Re-raise it: first plot is at `y`=151 again (step 0).
- Reset at cycle 700, asynchronous mid-cycle: `plot` and `doneAnimation` go to 0 immediately. After release with start still high, the animation restarts at `y`=151.
- Start held high after DONE for 100 cycles: no plots occur and `doneAnimation` stays 1.
